// File: rtl/exc_pipe_if.sv
// Core <-> exception unit bundle: stage flags in, flush/redirect and CP0 read values out.
// Pure wiring; the core side is the master, the exception unit is the slave.
interface exc_pipe_if #(
  parameter int ADDR_W = 32,
  parameter int HW_INT = 6
);
  logic              stall;
  logic              valid_F;
  logic [ADDR_W-1:0] pc_F;
  logic              ri_D;
  logic              sys_D;
  logic              bp_D;
  logic              eret_D;
  logic              ds_D;
  logic              ov_E;
  logic              ld_E;
  logic              st_E;
  logic [1:0]        size_E;
  logic [ADDR_W-1:0] addr_E;
  logic [HW_INT-1:0] hw_int;
  logic              cp0_we;
  logic [1:0]        cp0_sel;
  logic [ADDR_W-1:0] cp0_wdata;
  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;
  logic [4:0]        exc_code_M;
  logic [ADDR_W-1:0] status;
  logic [ADDR_W-1:0] cause;
  logic [ADDR_W-1:0] epc;
  logic [ADDR_W-1:0] badvaddr;

  modport master (
    output stall, valid_F, pc_F, ri_D, sys_D, bp_D, eret_D, ds_D,
           ov_E, ld_E, st_E, size_E, addr_E, hw_int, cp0_we, cp0_sel, cp0_wdata,
    input  flush, redirect_pc, exc_code_M, status, cause, epc, badvaddr
  );

  modport slave (
    input  stall, valid_F, pc_F, ri_D, sys_D, bp_D, eret_D, ds_D,
           ov_E, ld_E, st_E, size_E, addr_E, hw_int, cp0_we, cp0_sel, cp0_wdata,
    output flush, redirect_pc, exc_code_M, status, cause, epc, badvaddr
  );
endinterface

// File: rtl/exc_pipe.sv
// Precise exceptions: oldest cause rides D/E/M, commits at M with interrupts, ERET and CP0.
// Flush/redirect combinational from M; stall holds tracking regs and CP0, flush overrides stall.
module exc_pipe #(
  parameter int                ADDR_W  = 32,
  parameter int                HW_INT  = 6,
  parameter logic [ADDR_W-1:0] EXC_VEC = 32'hBFC0_0380
) (
  input  logic     clk,
  input  logic     resetn,
  exc_pipe_if.slave bus
);
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  typedef struct packed {
    logic              vld;
    logic              has_exc;
    logic [4:0]        code;
    logic [ADDR_W-1:0] pc;
    logic              bd;
    logic              eret;
    logic [ADDR_W-1:0] bad_addr;
  } stage_t;

  stage_t d_q, e_q, m_q;
  stage_t d_nxt, e_nxt, m_nxt;

  logic              sr_ie, sr_exl;
  logic [7:0]        sr_im;
  logic [HW_INT-1:0] ip_hw;
  logic [1:0]        ip_sw;
  logic              cause_bd;
  logic [4:0]        cause_code;
  logic [ADDR_W-1:0] epc_q, bva_q;

  logic [7:0]        ip;
  logic              misaligned;
  logic              int_take, exc_take, eret_take;
  logic [4:0]        commit_code;
  logic [ADDR_W-1:0] status_rd, cause_rd;

  always_comb begin
    ip = '0;
    ip[1:0] = ip_sw;
    ip[HW_INT+1:2] = ip_hw;
  end

  always_comb begin
    d_nxt     = '0;
    d_nxt.vld = bus.valid_F;
    d_nxt.pc  = bus.pc_F;
    if (bus.pc_F[1:0] != 2'b00) begin
      d_nxt.has_exc  = 1'b1;
      d_nxt.code     = EXC_ADEL;
      d_nxt.bad_addr = bus.pc_F;
    end
  end

  // Later stages only fill in a code when nothing older is already carried.
  always_comb begin
    e_nxt      = d_q;
    e_nxt.bd   = bus.ds_D;
    e_nxt.eret = bus.eret_D;
    if (!d_q.has_exc) begin
      if (bus.ri_D) begin
        e_nxt.has_exc = 1'b1;
        e_nxt.code    = EXC_RI;
      end else if (bus.sys_D) begin
        e_nxt.has_exc = 1'b1;
        e_nxt.code    = EXC_SYS;
      end else if (bus.bp_D) begin
        e_nxt.has_exc = 1'b1;
        e_nxt.code    = EXC_BP;
      end
    end
  end

  assign misaligned = ((bus.size_E == 2'd1) && bus.addr_E[0]) ||
                      ((bus.size_E == 2'd2) && (bus.addr_E[1:0] != 2'b00));

  always_comb begin
    m_nxt = e_q;
    if (!e_q.has_exc) begin
      if (bus.ov_E) begin
        m_nxt.has_exc = 1'b1;
        m_nxt.code    = EXC_OV;
      end else if (bus.ld_E && misaligned) begin
        m_nxt.has_exc  = 1'b1;
        m_nxt.code     = EXC_ADEL;
        m_nxt.bad_addr = bus.addr_E;
      end else if (bus.st_E && misaligned) begin
        m_nxt.has_exc  = 1'b1;
        m_nxt.code     = EXC_ADES;
        m_nxt.bad_addr = bus.addr_E;
      end
    end
  end

  assign int_take    = (|(ip & sr_im)) & sr_ie & ~sr_exl;
  assign exc_take    = m_q.vld & (int_take | m_q.has_exc);
  assign eret_take   = m_q.vld & ~exc_take & m_q.eret;
  assign commit_code = int_take ? EXC_INT : m_q.code;

  assign bus.flush       = exc_take | eret_take;
  assign bus.redirect_pc = exc_take ? EXC_VEC : epc_q;
  assign bus.exc_code_M  = exc_take ? commit_code : 5'h00;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_q <= '0;
      e_q <= '0;
      m_q <= '0;
    end else if (bus.flush) begin
      d_q <= '0;
      e_q <= '0;
      m_q <= '0;
    end else if (!bus.stall) begin
      d_q <= d_nxt;
      e_q <= e_nxt;
      m_q <= m_nxt;
    end
  end

  // A commit owns CP0 for its edge; an MTC0 in the same cycle is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr_ie      <= 1'b0;
      sr_exl     <= 1'b1;
      sr_im      <= '0;
      ip_hw      <= '0;
      ip_sw      <= '0;
      cause_bd   <= 1'b0;
      cause_code <= '0;
      epc_q      <= '0;
      bva_q      <= '0;
    end else begin
      ip_hw <= bus.hw_int;
      if (exc_take) begin
        sr_exl     <= 1'b1;
        cause_code <= commit_code;
        if (!sr_exl) begin
          epc_q    <= m_q.bd ? (m_q.pc - ADDR_W'(4)) : m_q.pc;
          cause_bd <= m_q.bd;
        end
        if (!int_take && ((m_q.code == EXC_ADEL) || (m_q.code == EXC_ADES)))
          bva_q <= m_q.bad_addr;
      end else if (eret_take) begin
        sr_exl <= 1'b0;
      end else if (bus.cp0_we && !bus.stall) begin
        case (bus.cp0_sel)
          2'd0: begin
            sr_ie  <= bus.cp0_wdata[0];
            sr_exl <= bus.cp0_wdata[1];
            sr_im  <= bus.cp0_wdata[15:8];
          end
          2'd1:    ip_sw <= bus.cp0_wdata[9:8];
          2'd2:    epc_q <= bus.cp0_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status_rd       = '0;
    status_rd[0]    = sr_ie;
    status_rd[1]    = sr_exl;
    status_rd[15:8] = sr_im;
    cause_rd        = '0;
    cause_rd[31]    = cause_bd;
    cause_rd[15:8]  = ip;
    cause_rd[6:2]   = cause_code;
  end

  assign bus.status   = status_rd;
  assign bus.cause    = cause_rd;
  assign bus.epc      = epc_q;
  assign bus.badvaddr = bva_q;
endmodule

// File: tb/tb_exc_pipe.sv
// Scoreboarded bench for exc_pipe: expected commits queued at issue, checked when flush appears.
module tb_exc_pipe;
  localparam int          ADDR_W  = 32;
  localparam int          HW_INT  = 6;
  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  exc_pipe_if #(.ADDR_W(ADDR_W), .HW_INT(HW_INT)) bus ();
  exc_pipe #(.ADDR_W(ADDR_W), .HW_INT(HW_INT), .EXC_VEC(EXC_VEC)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic ri, sys, bp, eret, ds, ov, ld, st;
    logic [1:0]  size;
    logic [31:0] addr;
  } instr_t;

  typedef struct packed {
    logic        flush;
    logic [31:0] redirect;
    logic [4:0]  code;
  } pre_t;

  typedef struct packed {
    logic        exl;
    logic [4:0]  exccode;
    logic        bd;
    logic [31:0] epc;
    logic [31:0] bva;
  } post_t;

  typedef struct packed {
    pre_t  pre;
    post_t post;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic        m_ie, m_exl, m_bd;
  logic [7:0]  m_im;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bva;

  function automatic pre_t snap_pre();
    pre_t p;
    p.flush    = bus.flush;
    p.redirect = bus.redirect_pc;
    p.code     = bus.exc_code_M;
    return p;
  endfunction

  function automatic post_t snap_post();
    post_t p;
    p.exl     = bus.status[1];
    p.exccode = bus.cause[6:2];
    p.bd      = bus.cause[31];
    p.epc     = bus.epc;
    p.bva     = bus.badvaddr;
    return p;
  endfunction

  task automatic model_reset();
    m_ie = 0; m_exl = 1; m_im = '0; m_code = '0; m_bd = 0; m_epc = '0; m_bva = '0;
    exp_q.delete();
  endtask

  task automatic model_push(input instr_t i);
    logic [4:0]  c;
    logic        has, intr, mis;
    logic [31:0] bad;
    exp_t        e;
    has = 1'b1;
    bad = i.addr;
    mis = ((i.size == 2'd1) && i.addr[0]) || ((i.size == 2'd2) && (i.addr[1:0] != 2'b00));
    if (i.pc[1:0] != 2'b00) begin c = 5'h04; bad = i.pc; end
    else if (i.ri)          c = 5'h0A;
    else if (i.sys)         c = 5'h08;
    else if (i.bp)          c = 5'h09;
    else if (i.ov)          c = 5'h0C;
    else if (i.ld && mis)   c = 5'h04;
    else if (i.st && mis)   c = 5'h05;
    else begin has = 1'b0; c = 5'h00; end
    intr = m_ie && !m_exl && (|({bus.hw_int, 2'b00} & m_im));
    if (intr || has) begin
      if (intr) c = 5'h00;
      if (!m_exl) begin
        m_epc = i.ds ? (i.pc - 32'd4) : i.pc;
        m_bd  = i.ds;
      end
      if (!intr && ((c == 5'h04) || (c == 5'h05))) m_bva = bad;
      m_exl = 1'b1;
      m_code = c;
      e.pre.flush = 1'b1; e.pre.redirect = EXC_VEC; e.pre.code = c;
      e.post.exl = m_exl; e.post.exccode = m_code; e.post.bd = m_bd;
      e.post.epc = m_epc; e.post.bva = m_bva;
      exp_q.push_back(e);
    end else if (i.eret) begin
      e.pre.flush = 1'b1; e.pre.redirect = m_epc; e.pre.code = 5'h00;
      m_exl = 1'b0;
      e.post.exl = m_exl; e.post.exccode = m_code; e.post.bd = m_bd;
      e.post.epc = m_epc; e.post.bva = m_bva;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.valid_F = 0; bus.pc_F = '0;
    bus.ri_D = 0; bus.sys_D = 0; bus.bp_D = 0; bus.eret_D = 0; bus.ds_D = 0;
    bus.ov_E = 0; bus.ld_E = 0; bus.st_E = 0; bus.size_E = '0; bus.addr_E = '0;
    bus.hw_int = '0; bus.cp0_we = 0; bus.cp0_sel = '0; bus.cp0_wdata = '0;
  endtask

  // Walk one instruction F->D->E; on return it sits in M.
  task automatic send(input instr_t i);
    model_push(i);
    bus.valid_F = 1; bus.pc_F = i.pc;
    @(posedge clk); #1;
    bus.valid_F = 0; bus.pc_F = '0;
    bus.ri_D = i.ri; bus.sys_D = i.sys; bus.bp_D = i.bp; bus.eret_D = i.eret; bus.ds_D = i.ds;
    @(posedge clk); #1;
    bus.ri_D = 0; bus.sys_D = 0; bus.bp_D = 0; bus.eret_D = 0; bus.ds_D = 0;
    bus.ov_E = i.ov; bus.ld_E = i.ld; bus.st_E = i.st; bus.size_E = i.size; bus.addr_E = i.addr;
    @(posedge clk); #1;
    bus.ov_E = 0; bus.ld_E = 0; bus.st_E = 0; bus.size_E = '0; bus.addr_E = '0;
  endtask

  task automatic cp0_write(input logic [1:0] sel, input logic [31:0] wdata);
    bus.cp0_we = 1; bus.cp0_sel = sel; bus.cp0_wdata = wdata;
    @(posedge clk); #1;
    bus.cp0_we = 0;
    if (sel == 2'd0) begin m_ie = wdata[0]; m_exl = wdata[1]; m_im = wdata[15:8]; end
    if (sel == 2'd2) m_epc = wdata;
  endtask

  task automatic wait_flush(output bit ok);
    int k;
    ok = 0;
    k = 0;
    while (!ok && k < 6) begin
      if (bus.flush === 1'b1) ok = 1;
      else begin @(posedge clk); #1; k++; end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got %b want 0", bus.flush); end
    n_cmp++; if (bus.exc_code_M !== 5'h00) begin n_bad++; $display("FAIL reset_code got %h want 00", bus.exc_code_M); end
    n_cmp++; if (bus.status !== 32'h0000_0002) begin n_bad++; $display("FAIL reset_status got %h want 00000002", bus.status); end
    n_cmp++; if (bus.cause !== 32'h0) begin n_bad++; $display("FAIL reset_cause got %h want 0", bus.cause); end
    n_cmp++; if (bus.epc !== 32'h0) begin n_bad++; $display("FAIL reset_epc got %h want 0", bus.epc); end
    n_cmp++; if (bus.badvaddr !== 32'h0) begin n_bad++; $display("FAIL reset_bva got %h want 0", bus.badvaddr); end
    resetn = 1;
    model_reset();
  endtask

  task automatic test_fetch_adel();
    instr_t i; exp_t e; bit ok;
    cp0_write(2'd0, 32'h0);
    i = '0; i.pc = 32'h0000_1002;
    send(i);
    wait_flush(ok); e = exp_q.pop_front();
    n_cmp++; if (!ok || snap_pre() !== e.pre) begin n_bad++; $display("FAIL adel_pre got %h want %h", snap_pre(), e.pre); end
    @(posedge clk); #1;
    n_cmp++; if (snap_post() !== e.post) begin n_bad++; $display("FAIL adel_post got %h want %h", snap_post(), e.post); end
  endtask

  task automatic test_priority();
    instr_t i; exp_t e; bit ok;
    cp0_write(2'd0, 32'h0);
    i = '0; i.pc = 32'h40; i.ri = 1; i.ov = 1;
    send(i);
    wait_flush(ok); e = exp_q.pop_front();
    n_cmp++; if (!ok || snap_pre() !== e.pre) begin n_bad++; $display("FAIL prio_pre got %h want %h", snap_pre(), e.pre); end
    @(posedge clk); #1;
    n_cmp++; if (snap_post() !== e.post) begin n_bad++; $display("FAIL prio_post got %h want %h", snap_post(), e.post); end
  endtask

  task automatic test_store_ds();
    instr_t i; exp_t e; bit ok;
    cp0_write(2'd0, 32'h0);
    i = '0; i.pc = 32'h80; i.ds = 1; i.st = 1; i.size = 2'd2; i.addr = 32'h1000_0006;
    send(i);
    wait_flush(ok); e = exp_q.pop_front();
    n_cmp++; if (!ok || snap_pre() !== e.pre) begin n_bad++; $display("FAIL ades_pre got %h want %h", snap_pre(), e.pre); end
    @(posedge clk); #1;
    n_cmp++; if (snap_post() !== e.post) begin n_bad++; $display("FAIL ades_post got %h want %h", snap_post(), e.post); end
  endtask

  task automatic test_mem_align();
    instr_t i; exp_t e; bit ok;
    i = '0; i.pc = 32'h100; i.ld = 1; i.size = 2'd1; i.addr = 32'h1000_0002;
    send(i);
    n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL align_half got %b want 0", bus.flush); end
    i = '0; i.pc = 32'h104; i.st = 1; i.size = 2'd0; i.addr = 32'h1000_0003;
    send(i);
    n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL align_byte got %b want 0", bus.flush); end
    i = '0; i.pc = 32'h120; i.ld = 1; i.size = 2'd2; i.addr = 32'h1000_0001;
    send(i);
    wait_flush(ok); e = exp_q.pop_front();
    n_cmp++; if (!ok || snap_pre() !== e.pre) begin n_bad++; $display("FAIL adel_ld_pre got %h want %h", snap_pre(), e.pre); end
    @(posedge clk); #1;
    n_cmp++; if (snap_post() !== e.post) begin n_bad++; $display("FAIL adel_ld_post got %h want %h", snap_post(), e.post); end
  endtask

  task automatic test_interrupt();
    instr_t i; exp_t e; bit ok;
    cp0_write(2'd0, 32'h0000_0401);
    bus.hw_int = 6'b000001;
    i = '0; i.pc = 32'h200;
    send(i);
    wait_flush(ok); e = exp_q.pop_front();
    n_cmp++; if (!ok || snap_pre() !== e.pre) begin n_bad++; $display("FAIL int_pre got %h want %h", snap_pre(), e.pre); end
    @(posedge clk); #1;
    n_cmp++; if (snap_post() !== e.post) begin n_bad++; $display("FAIL int_post got %h want %h", snap_post(), e.post); end
    i = '0; i.pc = 32'h204;
    send(i);
    n_cmp++; if (bus.flush !== 1'b0 || exp_q.size() != 0) begin n_bad++; $display("FAIL int_masked got flush %b want 0", bus.flush); end
    bus.hw_int = '0;
  endtask

  task automatic test_eret();
    instr_t i; exp_t e; bit ok;
    cp0_write(2'd0, 32'h0);
    i = '0; i.pc = 32'h300; i.sys = 1;
    send(i);
    wait_flush(ok); e = exp_q.pop_front();
    n_cmp++; if (!ok || snap_pre() !== e.pre) begin n_bad++; $display("FAIL sys_pre got %h want %h", snap_pre(), e.pre); end
    @(posedge clk); #1;
    n_cmp++; if (snap_post() !== e.post) begin n_bad++; $display("FAIL sys_post got %h want %h", snap_post(), e.post); end
    i = '0; i.pc = 32'h400; i.eret = 1;
    send(i);
    wait_flush(ok); e = exp_q.pop_front();
    n_cmp++; if (!ok || snap_pre() !== e.pre) begin n_bad++; $display("FAIL eret_pre got %h want %h", snap_pre(), e.pre); end
    @(posedge clk); #1;
    n_cmp++; if (snap_post() !== e.post) begin n_bad++; $display("FAIL eret_post got %h want %h", snap_post(), e.post); end
    i = '0; i.pc = 32'h500; i.bp = 1;
    send(i);
    wait_flush(ok); e = exp_q.pop_front();
    n_cmp++; if (!ok || snap_pre() !== e.pre) begin n_bad++; $display("FAIL bp_pre got %h want %h", snap_pre(), e.pre); end
    @(posedge clk); #1;
    n_cmp++; if (snap_post() !== e.post) begin n_bad++; $display("FAIL bp_post got %h want %h", snap_post(), e.post); end
    i = '0; i.pc = 32'h600; i.ri = 1;
    send(i);
    wait_flush(ok); e = exp_q.pop_front();
    n_cmp++; if (!ok || snap_pre() !== e.pre) begin n_bad++; $display("FAIL nested_pre got %h want %h", snap_pre(), e.pre); end
    @(posedge clk); #1;
    n_cmp++; if (snap_post() !== e.post) begin n_bad++; $display("FAIL nested_post got %h want %h", snap_post(), e.post); end
  endtask

  task automatic test_stall();
    instr_t i; exp_t e;
    cp0_write(2'd0, 32'h0);
    i = '0; i.pc = 32'h900; i.bp = 1;
    model_push(i);
    bus.valid_F = 1; bus.pc_F = i.pc;
    @(posedge clk); #1;
    bus.valid_F = 0; bus.pc_F = '0; bus.bp_D = 1;
    @(posedge clk); #1;
    bus.bp_D = 0; bus.stall = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL stall_hold%0d got %b want 0", k, bus.flush); end
    end
    bus.stall = 0;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_cmp++; if (snap_pre() !== e.pre) begin n_bad++; $display("FAIL stall_pre got %h want %h", snap_pre(), e.pre); end
    @(posedge clk); #1;
    n_cmp++; if (snap_post() !== e.post) begin n_bad++; $display("FAIL stall_post got %h want %h", snap_post(), e.post); end
  endtask

  task automatic test_reset_mid_flush();
    instr_t i; exp_t e; bit ok;
    cp0_write(2'd0, 32'h0);
    i = '0; i.pc = 32'h700; i.sys = 1;
    send(i);
    wait_flush(ok); e = exp_q.pop_front();
    n_cmp++; if (!ok || snap_pre() !== e.pre) begin n_bad++; $display("FAIL rstf_pre got %h want %h", snap_pre(), e.pre); end
    resetn = 0;
    #1;
    n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL rstf_flush got %b want 0", bus.flush); end
    n_cmp++; if (bus.exc_code_M !== 5'h00) begin n_bad++; $display("FAIL rstf_code got %h want 00", bus.exc_code_M); end
    n_cmp++; if (bus.status !== 32'h0000_0002) begin n_bad++; $display("FAIL rstf_status got %h want 00000002", bus.status); end
    n_cmp++; if (bus.cause !== 32'h0) begin n_bad++; $display("FAIL rstf_cause got %h want 0", bus.cause); end
    n_cmp++; if (bus.epc !== 32'h0 || bus.badvaddr !== 32'h0) begin n_bad++; $display("FAIL rstf_epc_bva got %h/%h want 0/0", bus.epc, bus.badvaddr); end
    model_reset();
    @(posedge clk); #1;
    resetn = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    @(posedge clk); #1;
    test_fetch_adel();
    test_priority();
    test_store_ds();
    test_mem_align();
    test_interrupt();
    test_eret();
    test_stall();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
